// File: rtl/alu_seq_if.sv
// Command and result handshakes of the ALU sequencer.
// The slave side is the sequencer; the master side issues commands and drains results.
interface alu_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        out_ovf;
    logic        out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_ovf, out_err
    );
endinterface

// File: rtl/alu_seq.sv
// Sequencing front-end for a one-bit-per-op 32-bit ALU.
// Multi-bit shifts are built by looping alu_res back into alu_a once per cycle.
module alu_seq (
    input  logic        clk,
    input  logic        rst_n,
    alu_seq_if.slave    bus,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [3:0]  alu_sel_o,
    input  logic [31:0] alu_res_i,
    input  logic        alu_ovf_i
);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] res_q, res_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            alu_a_q <= '0;
            alu_b_q <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    alu_a_d = bus.in_a;
                    alu_b_d = bus.in_b;
                    op_d    = bus.in_op;
                    cnt_d   = bus.in_b[4:0];
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    case (bus.in_op)
                        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9: state_d = EXEC;
                        4'd6, 4'd7, 4'd8: begin
                            // Zero-length shift never touches the ALU: a passes straight through.
                            if (bus.in_b[4:0] != 5'd0) begin
                                state_d = SHIFT;
                            end else begin
                                res_d   = bus.in_a;
                                state_d = DONE;
                            end
                        end
                        default: begin
                            res_d   = '0;
                            err_d   = 1'b1;
                            state_d = DONE;
                        end
                    endcase
                end
            end
            EXEC: begin
                res_d   = alu_res_i;
                ovf_d   = alu_ovf_i;
                state_d = DONE;
            end
            SHIFT: begin
                alu_a_d = alu_res_i;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    res_d   = alu_res_i;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.out_res   = res_q;
        bus.out_ovf   = ovf_q;
        bus.out_err   = err_q;
        alu_a_o       = alu_a_q;
        alu_b_o       = alu_b_q;
        alu_sel_o     = ((state_q == EXEC) || (state_q == SHIFT)) ? op_q : 4'd0;
    end

endmodule
